// File: rtl/uart_frame_sequencer.sv
// Collects FRAME_BYTES UART bytes into a frame and hands it downstream. The result frame
// that comes back is sent to the UART transmitter one byte at a time, byte [7:0] first.
module uart_frame_sequencer #(
   parameter int FRAME_BYTES    = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_data_ready,
   input  logic [7:0]               rx_data,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   output logic                     frame_valid,
   output logic [8*FRAME_BYTES-1:0] frame_data,
   input  logic                     frame_ready,
   input  logic                     result_valid,
   input  logic [8*FRAME_BYTES-1:0] result_data,
   output logic                     result_ready,
   input  logic                     flush,
   output logic                     timeout,
   output logic                     overrun,
   output logic [2:0]               dbg_state
);
   localparam int FRAME_W = 8*FRAME_BYTES;
   localparam int GAP_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES-2);
   localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES-1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COLLECT  = 3'd1,
      PRESENT  = 3'd2,
      WAIT_RES = 3'd3,
      SEND     = 3'd4,
      ARM      = 3'd5,
      DRAIN    = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
   logic [3:0]         tx_idx_q, tx_idx_d;
   logic               overrun_q, overrun_d;

   // Frame and result ports use valid/ready: a transfer happens in any cycle where both are
   // high. Both valids and readies here are pure state decodes, never waiting on the partner.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      frame_d      = frame_q;
      tx_sh_d      = tx_sh_q;
      tx_idx_d     = tx_idx_q;
      overrun_d    = overrun_q;
      tx_start     = 1'b0;
      timeout      = 1'b0;
      frame_valid  = 1'b0;
      result_ready = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_data_ready) begin
               frame_d[7:0] = rx_data;
               cnt_d        = 4'd1;
               gap_d        = '0;
               state_d      = COLLECT;
            end
         end
         COLLECT: begin
            if (rx_data_ready) begin
               for (int i = 0; i < FRAME_BYTES; i++) begin
                  if (cnt_q == 4'(i)) frame_d[8*i +: 8] = rx_data;
               end
               cnt_d = cnt_q + 4'd1;
               gap_d = '0;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = 4'd0;
                  state_d = PRESENT;
               end
            end else if (gap_q == GAP_LAST) begin
               // The current idle cycle completes TIMEOUT_CYCLES-1 cycles of silence.
               timeout = 1'b1;
               cnt_d   = 4'd0;
               gap_d   = '0;
               frame_d = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         PRESENT: begin
            frame_valid = 1'b1;
            if (frame_ready) state_d = WAIT_RES;
         end
         WAIT_RES: begin
            result_ready = 1'b1;
            if (result_valid) begin
               tx_sh_d  = result_data;
               tx_idx_d = 4'd0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = ARM;
            end
         end
         ARM: begin
            if (tx_busy) state_d = DRAIN;
         end
         DRAIN: begin
            if (!tx_busy) begin
               if (tx_idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  tx_idx_d = tx_idx_q + 4'd1;
                  tx_sh_d  = tx_sh_q >> 8;
                  state_d  = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rx_data_ready && state_q != IDLE && state_q != COLLECT) overrun_d = 1'b1;

      if (flush) begin
         state_d   = IDLE;
         cnt_d     = 4'd0;
         gap_d     = '0;
         overrun_d = 1'b0;
         tx_start  = 1'b0;
         timeout   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         gap_q     <= '0;
         frame_q   <= '0;
         tx_sh_q   <= '0;
         tx_idx_q  <= 4'd0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         frame_q   <= frame_d;
         tx_sh_q   <= tx_sh_d;
         tx_idx_q  <= tx_idx_d;
         overrun_q <= overrun_d;
      end
   end

   assign tx_data    = tx_sh_q[7:0];
   assign frame_data = frame_q;
   assign overrun    = overrun_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Self-checking bench for uart_frame_sequencer: vector table, directed corner cases and
// randomized transactions checked against a byte-level reference model.
module tb_uart_frame_sequencer;
   localparam int FB = 4;
   localparam int TO = 50;
   localparam logic [2:0] S_IDLE = 3'd0, S_COLLECT = 3'd1, S_PRESENT = 3'd2,
                          S_WAIT_RES = 3'd3, S_SEND = 3'd4, S_ARM = 3'd5, S_DRAIN = 3'd6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_data_ready = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_busy;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          frame_valid;
   logic [8*FB-1:0] frame_data;
   logic          frame_ready = 1'b1;
   logic          result_valid = 1'b0;
   logic [8*FB-1:0] result_data = '0;
   logic          result_ready;
   logic          flush = 1'b0;
   logic          timeout;
   logic          overrun;
   logic [2:0]    dbg_state;

   uart_frame_sequencer #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
      .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
      .flush(flush), .timeout(timeout), .overrun(overrun), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];
   int n_starts = 0;
   int busy_len = 100;
   logic model_en = 1'b0;
   int both_err = 0;
   logic [7:0] mon_byte;

   typedef struct {
      logic        rdy;
      logic [7:0]  b;
      logic        fr;
      logic        exp_fv;
      logic        exp_rr;
      logic [31:0] exp_fd;
      logic [2:0]  exp_st;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_data_ready = 1'b1;
      tick();
      rx_data_ready = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b[FB], input int max_gap);
      for (int i = 0; i < FB; i++) begin
         send_byte(b[i]);
         if (i < FB-1) repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int i;
      i = 0;
      while (dbg_state !== s && i < budget) begin
         tick();
         i++;
      end
      check(name, 64'(dbg_state), 64'(s));
   endtask

   // Reference model: frame is the bytes in arrival order, first byte least significant.
   function automatic logic [31:0] pack_frame(input logic [7:0] b[FB]);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < FB; i++) r = r + (32'(b[i]) << (8*i));
      return r;
   endfunction

   task automatic push_result(input logic [31:0] w);
      for (int i = 0; i < FB; i++) exp_q.push_back(w[8*i +: 8]);
   endtask

   // UART transmitter model: busy rises one cycle after tx_start and stays high busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && model_en) begin
            n_starts++;
            mon_byte = tx_data;
            check("tx_byte_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("tx_byte", 64'(mon_byte), 64'(exp_q.pop_front()));
            @(posedge clk);
            #1;
            tx_busy = 1'b1;
            check("tx_start_one_cycle", 64'(tx_start), 64'd0);
            repeat (busy_len) @(posedge clk);
            #1;
            check("tx_data_held", 64'(tx_data), 64'(mon_byte));
            tx_busy = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (frame_valid && result_ready) both_err++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b[FB];
      logic [31:0] rw;
      int k;
      int err;

      vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 32'h00000000, S_IDLE};
      vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 32'h00000011, S_COLLECT};
      vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 32'h00002211, S_COLLECT};
      vecs[3] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 32'h00332211, S_COLLECT};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h44332211, S_PRESENT};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h44332211, S_WAIT_RES};

      // Reset holds everything at zero, even with a byte arriving.
      repeat (3) tick();
      rx_data_ready = 1'b1;
      rx_data = 8'h99;
      #1;
      check("reset_tx_start", 64'(tx_start), 64'd0);
      check("reset_tx_data", 64'(tx_data), 64'd0);
      check("reset_frame_valid", 64'(frame_valid), 64'd0);
      check("reset_result_ready", 64'(result_ready), 64'd0);
      check("reset_timeout", 64'(timeout), 64'd0);
      check("reset_overrun", 64'(overrun), 64'd0);
      check("reset_frame_data", 64'(frame_data), 64'd0);
      tick();
      rx_data_ready = 1'b0;
      check("reset_state", 64'(dbg_state), 64'(S_IDLE));
      reset = 1'b0;
      tick();

      // Frame assembly table.
      for (int i = 0; i < 6; i++) begin
         rx_data_ready = vecs[i].rdy;
         rx_data = vecs[i].b;
         frame_ready = vecs[i].fr;
         #1;
         check($sformatf("vec%0d_frame_valid", i), 64'(frame_valid), 64'(vecs[i].exp_fv));
         check($sformatf("vec%0d_result_ready", i), 64'(result_ready), 64'(vecs[i].exp_rr));
         check($sformatf("vec%0d_frame_data", i), 64'(frame_data), 64'(vecs[i].exp_fd));
         check($sformatf("vec%0d_state", i), 64'(dbg_state), 64'(vecs[i].exp_st));
         tick();
      end
      rx_data_ready = 1'b0;

      // Echo of 0xDEADBEEF with a 100-cycle busy transmitter.
      model_en = 1'b1;
      busy_len = 100;
      n_starts = 0;
      push_result(32'hDEADBEEF);
      result_data = 32'hDEADBEEF;
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
      check("echo_tx_start_latency", 64'(tx_start), 64'd1);
      check("echo_first_byte", 64'(tx_data), 64'hEF);
      wait_state(S_IDLE, 1000, "echo_return_idle");
      check("echo_start_count", 64'(n_starts), 64'd4);
      check("echo_queue_empty", 64'(exp_q.size()), 64'd0);

      // Overrun during DRAIN, then flush clears it.
      b = '{8'h05, 8'h06, 8'h07, 8'h08};
      send_frame(b, 0);
      check("ovr_frame_valid", 64'(frame_valid), 64'd1);
      tick();
      busy_len = 10;
      push_result(32'h01020304);
      result_data = 32'h01020304;
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
      wait_state(S_DRAIN, 50, "ovr_reach_drain");
      send_byte(8'h5A);
      check("ovr_set", 64'(overrun), 64'd1);
      wait_state(S_IDLE, 500, "ovr_return_idle");
      check("ovr_queue_empty", 64'(exp_q.size()), 64'd0);
      check("ovr_sticky", 64'(overrun), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_clears_overrun", 64'(overrun), 64'd0);
      check("flush_state", 64'(dbg_state), 64'(S_IDLE));

      // Randomized transactions against the reference model.
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < FB; i++) b[i] = 8'($urandom_range(0, 255));
         frame_ready = 1'b0;
         send_frame(b, 3);
         check("rnd_frame_valid_latency", 64'(frame_valid), 64'd1);
         check("rnd_frame_data", 64'(frame_data), 64'(pack_frame(b)));
         repeat ($urandom_range(0, 3)) tick();
         frame_ready = 1'b1;
         tick();
         frame_ready = 1'b0;
         check("rnd_result_ready", 64'(result_ready), 64'd1);
         repeat ($urandom_range(0, 3)) tick();
         rw = $urandom;
         busy_len = $urandom_range(1, 8);
         push_result(rw);
         result_data = rw;
         result_valid = 1'b1;
         tick();
         result_valid = 1'b0;
         wait_state(S_IDLE, 500, "rnd_return_idle");
         check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
      end
      frame_ready = 1'b1;

      // Timeout: two bytes then silence.
      send_byte(8'h01);
      send_byte(8'h02);
      k = 1;
      while (!timeout && k < 200) begin
         tick();
         k++;
      end
      check("timeout_delay", 64'(k), 64'd49);
      tick();
      check("timeout_one_cycle", 64'(timeout), 64'd0);
      check("timeout_idle", 64'(dbg_state), 64'(S_IDLE));
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_frame(b, 0);
      check("timeout_byte0", 64'(frame_data[7:0]), 64'hAA);
      check("timeout_refill", 64'(frame_data), 64'(pack_frame(b)));
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // A byte in the expiry cycle wins over the timeout.
      send_byte(8'h10);
      send_byte(8'h20);
      repeat (48) tick();
      rx_data = 8'h77;
      rx_data_ready = 1'b1;
      #1;
      check("late_byte_no_timeout", 64'(timeout), 64'd0);
      tick();
      rx_data_ready = 1'b0;
      check("late_byte_collect", 64'(dbg_state), 64'(S_COLLECT));
      send_byte(8'h80);
      check("late_byte_frame", 64'(frame_data), 64'h80772010);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // Backpressure: frame held stable while frame_ready is low.
      frame_ready = 1'b0;
      b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
      send_frame(b, 0);
      err = 0;
      for (int i = 0; i < 20; i++) begin
         if (frame_valid !== 1'b1 || frame_data !== pack_frame(b)) err++;
         tick();
      end
      check("bp_stable", 64'(err), 64'd0);
      frame_ready = 1'b1;
      tick();
      check("bp_accepted", 64'(dbg_state), 64'(S_WAIT_RES));

      // Reset while waiting in ARM.
      model_en = 1'b0;
      result_data = 32'h55667788;
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
      check("abort_send_start", 64'(tx_start), 64'd1);
      tick();
      check("abort_in_arm", 64'(dbg_state), 64'(S_ARM));
      reset = 1'b1;
      #1;
      check("abort_tx_start", 64'(tx_start), 64'd0);
      check("abort_state", 64'(dbg_state), 64'(S_IDLE));
      check("abort_tx_data", 64'(tx_data), 64'd0);
      check("abort_frame_data", 64'(frame_data), 64'd0);
      k = 0;
      repeat (3) begin
         tick();
         if (tx_start) k++;
      end
      reset = 1'b0;
      repeat (3) begin
         tick();
         if (tx_start) k++;
      end
      check("abort_no_tx_start", 64'(k), 64'd0);
      b = '{8'h3C, 8'h4D, 8'h5E, 8'h6F};
      send_frame(b, 2);
      check("post_reset_frame", 64'(frame_data), 64'(pack_frame(b)));
      check("post_reset_frame_valid", 64'(frame_valid), 64'd1);

      check("never_fv_and_rr", 64'(both_err), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 Parameter FRAME_BYTES, default 4: bytes per frame (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle gap between bytes of one frame, in clk cycles.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data_ready  input  1  one-cycle strobe from the UART receiver: rx_data is valid.
REQ-006 rx_data  input  8  received byte.
REQ-007 tx_busy  input  1  UART transmitter busy.
REQ-008 tx_start  output  1  one-cycle strobe to the UART transmitter.
REQ-009 tx_data  output  8  byte to transmit; held stable from tx_start until tx_busy falls.
REQ-010 frame_valid  output  1  assembled frame is available to the downstream datapath.
REQ-011 frame_data  output  8*FRAME_BYTES  assembled frame; first received byte in [7:0].
REQ-012 frame_ready  input  1  downstream accepts the frame.
REQ-013 result_valid  input  1  downstream result is available.
REQ-014 result_data  input  8*FRAME_BYTES  result frame; byte [7:0] is transmitted first.
REQ-015 result_ready  output  1  sequencer accepts the result.
REQ-016 flush  input  1  synchronous abort strobe (debounced button).
REQ-017 timeout  output  1  one-cycle pulse: partial frame discarded.
REQ-018 overrun  output  1  sticky: a byte arrived while not collecting.

Function
REQ-019 FSM states: IDLE, COLLECT, PRESENT, WAIT_RES, SEND, ARM, DRAIN.
REQ-020 IDLE: on rx_data_ready, the byte is stored at index 0, byte count = 1, next state COLLECT.
REQ-021 COLLECT: each rx_data_ready stores the byte at index = byte count and increments the count; when the stored byte is byte FRAME_BYTES-1, next state PRESENT.
REQ-022 COLLECT: the gap counter resets on every byte; when it reaches TIMEOUT_CYCLES-1 with no byte, the partial frame is discarded, timeout pulses for 1 cycle, and next state IDLE.
REQ-023 PRESENT: frame_valid = 1 and frame_data is stable; frame_valid && frame_ready in one cycle completes the transfer, next state WAIT_RES.
REQ-024 WAIT_RES: result_ready = 1; result_valid && result_ready latches result_data into a tx shift register, byte index = 0, next state SEND.
REQ-025 SEND: if tx_busy = 0, tx_start = 1 for exactly 1 cycle with tx_data = current byte, next state ARM; if tx_busy = 1, remain in SEND.
REQ-026 ARM: wait for tx_busy = 1, then go to DRAIN.
REQ-027 DRAIN: wait for tx_busy = 0; if the last byte was just sent, go to IDLE, else increment the byte index and go to SEND.
REQ-028 rx_data_ready in PRESENT, WAIT_RES, SEND, ARM or DRAIN: the byte is dropped and overrun is set to 1.
REQ-029 rx_data_ready in the same cycle as a timeout expiry: the byte is stored, the gap counter resets, and no timeout occurs.
REQ-030 flush has priority over every other event: next state IDLE, byte count = 0, gap counter = 0, overrun = 0, no tx_start, no timeout pulse.
REQ-031 frame_valid and result_ready are combinational decodes of the state; they are never asserted simultaneously.
REQ-032 Latency: frame_valid rises on the cycle after the rx_data_ready of the last byte.
REQ-033 tx_start rises on the cycle after the result handshake, provided tx_busy = 0.

Reset
REQ-034 While reset = 1 the sequencer holds: state IDLE; byte count, gap counter and byte index = 0; frame_data and tx shift register = 0.
REQ-035 While reset = 1, all outputs are 0: tx_start, tx_data, frame_valid, result_ready, timeout, overrun.
REQ-036 Reset during any state, including mid-transmit, aborts immediately with no further tx_start.
REQ-037 After reset is released, the first rx_data_ready is treated as byte 0.

Verification
REQ-038 Frame assembly: bytes 0x11, 0x22, 0x33, 0x44 with frame_ready = 1 -> frame_data = 0x44332211, frame_valid high for 1 cycle.
REQ-039 Echo: result_data = 0xDEADBEEF with tx_busy modelled (high 1 cycle after tx_start for 100 cycles) -> tx_data sequence EF, BE, AD, DE with 4 tx_start pulses, then IDLE.
REQ-040 Timeout: TIMEOUT_CYCLES = 50, 2 bytes then silence -> timeout pulses 49 cycles after the 2nd byte; next byte 0xAA lands at frame_data[7:0].
REQ-041 Overrun: byte arrives during DRAIN -> overrun = 1 and transmitted bytes unchanged; flush -> overrun = 0 and state IDLE.
REQ-042 Backpressure and abort: frame_ready held low for 20 cycles -> frame_valid and frame_data stable throughout; reset asserted during ARM -> tx_start = 0 and state IDLE.
